// File: rtl/fsmd_pkg.sv
// Shared definitions for the matrix-multiply FSMD result path.
package fsmd_pkg;

  localparam int N_RESULTS_DEF = 9;
  localparam int DATA_W_DEF    = 16;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    SHOW    = 2'd1,
    HELD    = 2'd2,
    DONE    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability counter for a push-button.
// Emits the debounced level and one-cycle rise/fall pulses.
module button_debouncer #(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, count consecutive disagreeing samples, toggle after DEB_CYCLES of them
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
          rise  <= sync2;
          fall  <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/result_display_sequencer.sv
// Captures the controller's nine results and steps through them on a
// debounced button press, handshaking Show_DATA / Done_Flag back.
module result_display_sequencer
  import fsmd_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int N_RESULTS  = N_RESULTS_DEF,
  parameter int DEB_CYCLES = 4,
  parameter int IDX_W      = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              btn_raw,
  input  logic              ld_out,
  input  logic [DATA_W-1:0] result_in,
  input  logic              Count_En,
  input  logic              NEW_OUTPUT,
  output logic              Show_DATA,
  output logic              Done_Flag,
  output logic [DATA_W-1:0] disp_data,
  output logic [IDX_W-1:0]  disp_idx,
  output logic              disp_valid,
  output logic              overflow_err
);

  seq_state_t        state;
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] res_buf [N_RESULTS];
  logic              btn_rise;
  logic              btn_fall;
  logic              wr_ok;

  // NEW_OUTPUT is informational only: advancing in SHOW never waits on it
  logic unused_new_output;
  assign unused_new_output = NEW_OUTPUT;

  button_debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debouncer (
    .CLK     (CLK),
    .RST     (RST),
    .btn_raw (btn_raw),
    .level   (Show_DATA),
    .rise    (btn_rise),
    .fall    (btn_fall)
  );

  assign wr_ok = ld_out && (state == CAPTURE) && (wr_ptr < IDX_W'(N_RESULTS));

  // Result buffer write; contents are not reset, wr_ptr alone marks validity
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      res_buf[wr_ptr] <= result_in;
    end
  end

  // Sequencer FSM with pointers, done pulse and sticky overflow flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= CAPTURE;
      wr_ptr       <= '0;
      rd_idx       <= '0;
      Done_Flag    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      Done_Flag <= 1'b0;
      if (ld_out && !wr_ok) begin
        overflow_err <= 1'b1;
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case (state)
        CAPTURE: begin
          if (Count_En) begin
            state <= SHOW;
          end
        end
        SHOW: begin
          if (!Count_En) begin
            state  <= CAPTURE;
            rd_idx <= '0;
          end else if (btn_rise) begin
            state <= HELD;
          end
        end
        HELD: begin
          if (!Count_En) begin
            state  <= CAPTURE;
            rd_idx <= '0;
          end else if (btn_fall) begin
            if (rd_idx == IDX_W'(N_RESULTS - 1)) begin
              state     <= DONE;
              Done_Flag <= 1'b1;
            end else begin
              rd_idx <= rd_idx + 1'b1;
              state  <= SHOW;
            end
          end
        end
        DONE: begin
          wr_ptr <= '0;
          rd_idx <= '0;
          state  <= CAPTURE;
        end
      endcase
    end
  end

  assign disp_idx   = rd_idx;
  assign disp_valid = Count_En && (rd_idx < wr_ptr);
  assign disp_data  = disp_valid ? res_buf[rd_idx] : '0;

endmodule

// File: tb/tb_result_display_sequencer.sv
// Randomised and directed bench for result_display_sequencer with a
// behavioural reference model and per-cycle output comparison.
module tb_result_display_sequencer;

  localparam int DW  = 16;
  localparam int NR  = 9;
  localparam int DEB = 4;
  localparam int IW  = 4;

  localparam int PH_CAPT = 0;
  localparam int PH_SHOW = 1;
  localparam int PH_HELD = 2;
  localparam int PH_DONE = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          btn_raw = 1'b1;
  logic          ld_out = 1'b0;
  logic [DW-1:0] result_in = '0;
  logic          Count_En = 1'b0;
  logic          NEW_OUTPUT = 1'b1;
  logic          Show_DATA;
  logic          Done_Flag;
  logic [DW-1:0] disp_data;
  logic [IW-1:0] disp_idx;
  logic          disp_valid;
  logic          overflow_err;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  result_display_sequencer #(
    .DATA_W     (DW),
    .N_RESULTS  (NR),
    .DEB_CYCLES (DEB),
    .IDX_W      (IW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .btn_raw      (btn_raw),
    .ld_out       (ld_out),
    .result_in    (result_in),
    .Count_En     (Count_En),
    .NEW_OUTPUT   (NEW_OUTPUT),
    .Show_DATA    (Show_DATA),
    .Done_Flag    (Done_Flag),
    .disp_data    (disp_data),
    .disp_idx     (disp_idx),
    .disp_valid   (disp_valid),
    .overflow_err (overflow_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button seen two samples late; level flips once the delayed value has
  // disagreed for DEB consecutive samples. Results held in a queue.
  bit m_s1 = 0, m_s2 = 0, m_lvl = 0;
  int m_run = 0;
  bit m_rise_pend = 0, m_fall_pend = 0, m_rise = 0, m_fall = 0;
  int m_phase = PH_CAPT;
  int m_q[$];
  int m_rd = 0;
  bit m_ovf = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
      m_rise_pend = 0; m_fall_pend = 0;
      m_phase = PH_CAPT; m_q.delete(); m_rd = 0; m_ovf = 0;
    end else begin
      m_rise = m_rise_pend;
      m_fall = m_fall_pend;
      m_rise_pend = 0;
      m_fall_pend = 0;
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = m_s2;
          m_run = 0;
          m_rise_pend = m_lvl;
          m_fall_pend = !m_lvl;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;

      if (ld_out) begin
        if (m_phase == PH_CAPT && m_q.size() < NR) m_q.push_back(int'(result_in));
        else m_ovf = 1;
      end

      if (m_phase == PH_DONE) begin
        m_q.delete();
        m_rd = 0;
        m_phase = PH_CAPT;
      end else if (m_phase == PH_CAPT) begin
        if (Count_En) m_phase = PH_SHOW;
      end else if (!Count_En) begin
        m_phase = PH_CAPT;
        m_rd = 0;
      end else if (m_phase == PH_SHOW && m_rise) begin
        m_phase = PH_HELD;
      end else if (m_phase == PH_HELD && m_fall) begin
        if (m_rd == NR - 1) m_phase = PH_DONE;
        else begin
          m_rd++;
          m_phase = PH_SHOW;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          e_valid;
  logic [31:0] e_data;

  always @(negedge CLK) begin
    e_valid = Count_En && (m_rd < m_q.size());
    e_data  = e_valid ? 32'(m_q[m_rd]) : 32'd0;
    chk("Show_DATA", 32'(Show_DATA), 32'(m_lvl));
    chk("Done_Flag", 32'(Done_Flag), 32'(m_phase == PH_DONE));
    chk("disp_valid", 32'(disp_valid), 32'(e_valid));
    chk("disp_idx", 32'(disp_idx), 32'(m_rd));
    chk("disp_data", 32'(disp_data), e_data);
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    if (Done_Flag) done_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic press_release(input int hold);
    btn_raw = 1'b1;
    step(hold);
    btn_raw = 1'b0;
    step(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int len;
  bit b;

  initial begin
    // Reset with the button held
    step(2);
    chk("rst_show", 32'(Show_DATA), 32'd0);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_data", 32'(disp_data), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    RST = 1'b1;
    step(5);
    chk("deb_lat_5", 32'(Show_DATA), 32'd0);
    step(1);
    chk("deb_lat_6", 32'(Show_DATA), 32'd1);
    btn_raw = 1'b0;
    step(8);

    // Nine loads, the last coinciding with Count_En rising
    for (int v = 1; v <= 9; v++) begin
      ld_out = 1'b1;
      result_in = DW'(v);
      if (v == 9) Count_En = 1'b1;
      step(1);
    end
    ld_out = 1'b0;
    chk("first_valid", 32'(disp_valid), 32'd1);
    chk("first_idx", 32'(disp_idx), 32'd0);
    chk("first_data", 32'(disp_data), 32'd1);

    // Nine clean press/release pairs; ld_out during the DONE cycle
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      chk("step_data", 32'(disp_data), 32'(i + 1));
      btn_raw = 1'b1;
      step(8);
      btn_raw = 1'b0;
      if (i == 8) begin
        step(7);
        chk("done_pulse", 32'(Done_Flag), 32'd1);
        ld_out = 1'b1;
        result_in = 16'h0077;
        step(1);
        ld_out = 1'b0;
      end else begin
        step(8);
      end
    end
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_idx", 32'(disp_idx), 32'd0);
    chk("done_valid", 32'(disp_valid), 32'd0);
    chk("done_ld_ovf", 32'(overflow_err), 32'd1);

    // Bounce shorter than DEB cycles
    Count_En = 1'b0;
    step(1);
    for (int v = 11; v <= 19; v++) begin
      ld_out = 1'b1;
      result_in = DW'(v);
      step(1);
    end
    ld_out = 1'b0;
    Count_En = 1'b1;
    step(1);
    repeat (4) begin
      btn_raw = 1'b1;
      step(3);
      btn_raw = 1'b0;
      step(3);
    end
    step(6);
    chk("bounce_show", 32'(Show_DATA), 32'd0);
    chk("bounce_idx", 32'(disp_idx), 32'd0);

    // Advance to index 5, press and reset while held
    repeat (5) press_release(8);
    btn_raw = 1'b1;
    step(8);
    chk("held_idx", 32'(disp_idx), 32'd5);
    chk("held_data", 32'(disp_data), 32'd16);
    RST = 1'b0;
    #1;
    chk("arst_idx", 32'(disp_idx), 32'd0);
    chk("arst_show", 32'(Show_DATA), 32'd0);
    chk("arst_valid", 32'(disp_valid), 32'd0);
    chk("arst_ovf", 32'(overflow_err), 32'd0);
    step(2);
    btn_raw = 1'b0;
    Count_En = 1'b0;
    RST = 1'b1;
    step(2);

    // Ten loads: the tenth is dropped, buf[8] keeps the ninth
    for (int v = 101; v <= 110; v++) begin
      ld_out = 1'b1;
      result_in = DW'(v);
      step(1);
    end
    ld_out = 1'b0;
    chk("ovf_set", 32'(overflow_err), 32'd1);
    Count_En = 1'b1;
    step(1);
    repeat (8) press_release(8);
    chk("ovf_idx8", 32'(disp_idx), 32'd8);
    chk("ovf_buf8", 32'(disp_data), 32'd109);
    press_release(8);
    chk("ovf_sticky", 32'(overflow_err), 32'd1);
    Count_En = 1'b0;
    step(2);

    // Randomised traffic
    RST = 1'b0;
    step(1);
    RST = 1'b1;
    for (int c = 0; c < 3000; c += len) begin
      len = $urandom_range(1, 10);
      b = 1'($urandom_range(0, 1));
      btn_raw = b;
      for (int k = 0; k < len; k++) begin
        ld_out = ($urandom_range(0, 5) == 0);
        result_in = DW'($urandom);
        if ($urandom_range(0, 59) == 0) Count_En = !Count_En;
        step(1);
      end
    end
    ld_out = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
